// File: rtl/ddr_ram_burst_arbiter.sv
// Two-master burst arbiter and sequencer for a simple dual-port RAM.
// Grants one write or read burst at a time using round-robin arbitration.
// It drives the RAM ports beat by beat. Read data is returned through a
// 2-entry buffer that hides the RAM read latency.
module ddr_ram_burst_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter string       OUTPUT_REG = "TRUE"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_cmd_valid,
  output logic                  m0_cmd_ready,
  input  logic                  m0_cmd_write,
  input  logic [ADDR_WIDTH-1:0] m0_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  m0_cmd_len,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m0_wvalid,
  output logic                  m0_wready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  output logic                  m0_rlast,
  input  logic                  m1_cmd_valid,
  output logic                  m1_cmd_ready,
  input  logic                  m1_cmd_write,
  input  logic [ADDR_WIDTH-1:0] m1_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  m1_cmd_len,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  output logic                  m1_rlast,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy
);

  // 1 when the RAM read data arrives one cycle after re.
  localparam bit OutReg = (OUTPUT_REG == "TRUE");

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;
  state_e state_q, state_d;

  logic                  owner_q, last_grant_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q, cnt_q;
  logic                  inflight_q, inflight_last_q;
  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [1:0]            buf_last_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            occ_q, occ_d;

  logic                  grant1, accept, sel_write, wvalid_own, rready_own;
  logic                  beat_last, wbeat, issue, push, pop, push_last, rvalid_any;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;

  // Arbitration, beat handshakes and read-issue decision.
  always_comb begin
    // Both requesting: the master not granted last wins.
    grant1     = m1_cmd_valid & (~m0_cmd_valid | ~last_grant_q);
    accept     = (state_q == StIdle) & (m0_cmd_valid | m1_cmd_valid);
    sel_write  = grant1 ? m1_cmd_write : m0_cmd_write;
    wvalid_own = owner_q ? m1_wvalid : m0_wvalid;
    rready_own = owner_q ? m1_rready : m0_rready;
    beat_last  = (cnt_q == len_q);
    wbeat      = (state_q == StWrite) & wvalid_own;
    rvalid_any = (occ_q != 2'd0);
    pop        = rvalid_any & rready_own;
    // Only issue when the beat is guaranteed a buffer slot on arrival.
    issue      = (state_q == StRead) &
                 (({1'b0, occ_q} + {2'b00, OutReg & inflight_q}) < (3'd2 + {2'b00, pop}));
    push       = OutReg ? inflight_q : issue;
    push_last  = OutReg ? inflight_last_q : beat_last;
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    head_data  = buf_data_q[rd_ptr_q];
    head_last  = buf_last_q[rd_ptr_q];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = sel_write ? StWrite : StRead;
      StWrite: if (wbeat && beat_last) state_d = StIdle;
      StRead:  if (issue && beat_last) state_d = StDrain;
      StDrain: if (occ_d == 2'd0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Burst context: owner, round-robin history, address and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
    end else if (accept) begin
      owner_q      <= grant1;
      last_grant_q <= grant1;
      addr_q       <= grant1 ? m1_cmd_addr : m0_cmd_addr;
      len_q        <= grant1 ? m1_cmd_len : m0_cmd_len;
      cnt_q        <= '0;
    end else if (wbeat || issue) begin
      addr_q       <= addr_q + ADDR_WIDTH'(1);
      cnt_q        <= cnt_q + LEN_WIDTH'(1);
    end
  end

  // Track the read that is still in the RAM output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= OutReg & issue;
      inflight_last_q <= issue & beat_last;
    end
  end

  // 2-entry read return buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q    <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      occ_q         <= 2'd0;
    end else begin
      if (push) begin
        buf_data_q[wr_ptr_q] <= ram_rdata;
        buf_last_q[wr_ptr_q] <= push_last;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_d;
    end
  end

  // Output decode; cmd_ready is also forced low while reset is held.
  always_comb begin
    m0_cmd_ready = rst_n & accept & ~grant1;
    m1_cmd_ready = rst_n & accept & grant1;
    m0_wready    = (state_q == StWrite) & ~owner_q;
    m1_wready    = (state_q == StWrite) & owner_q;
    m0_rvalid    = rvalid_any & ~owner_q;
    m1_rvalid    = rvalid_any & owner_q;
    m0_rdata     = m0_rvalid ? head_data : '0;
    m1_rdata     = m1_rvalid ? head_data : '0;
    m0_rlast     = m0_rvalid & head_last;
    m1_rlast     = m1_rvalid & head_last;
    ram_we       = wbeat;
    ram_waddr    = wbeat ? addr_q : '0;
    ram_wdata    = wbeat ? (owner_q ? m1_wdata : m0_wdata) : '0;
    ram_re       = issue;
    ram_raddr    = issue ? addr_q : '0;
    busy         = (state_q != StIdle);
  end

endmodule

// File: tb/tb_ddr_ram_burst_arbiter.sv
// Directed bench for ddr_ram_burst_arbiter with a behavioural dual-port RAM.
module tb_ddr_ram_burst_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m0_cmd_valid, m0_cmd_ready, m0_cmd_write, m0_wvalid, m0_wready;
  logic       m0_rvalid, m0_rready, m0_rlast;
  logic [8:0] m0_cmd_addr;
  logic [7:0] m0_cmd_len, m0_wdata, m0_rdata;
  logic       m1_cmd_valid, m1_cmd_ready, m1_cmd_write, m1_wvalid, m1_wready;
  logic       m1_rvalid, m1_rready, m1_rlast;
  logic [8:0] m1_cmd_addr;
  logic [7:0] m1_cmd_len, m1_wdata, m1_rdata;
  logic       ram_we, ram_re, busy;
  logic [8:0] ram_waddr, ram_raddr;
  logic [7:0] ram_wdata, ram_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem     [512];
  logic [7:0] exp_mem [512];

  always #5 clk = ~clk;

  ddr_ram_burst_arbiter #(
    .DATA_WIDTH(8), .ADDR_WIDTH(9), .LEN_WIDTH(8), .OUTPUT_REG("TRUE")
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_write(m0_cmd_write),
    .m0_cmd_addr(m0_cmd_addr), .m0_cmd_len(m0_cmd_len), .m0_wdata(m0_wdata),
    .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_rdata(m0_rdata),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rlast(m0_rlast),
    .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_write(m1_cmd_write),
    .m1_cmd_addr(m1_cmd_addr), .m1_cmd_len(m1_cmd_len), .m1_wdata(m1_wdata),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_rdata(m1_rdata),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rlast(m1_rlast),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .busy(busy)
  );

  // RAM model with registered read output, updated only while re is high.
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input bit m);
    return m ? m1_cmd_ready : m0_cmd_ready;
  endfunction

  task automatic set_cmd(input bit m, input bit v, input bit w, input int unsigned a,
                         input int unsigned l);
    if (m) begin
      m1_cmd_valid = v; m1_cmd_write = w; m1_cmd_addr = 9'(a); m1_cmd_len = 8'(l);
    end else begin
      m0_cmd_valid = v; m0_cmd_write = w; m0_cmd_addr = 9'(a); m0_cmd_len = 8'(l);
    end
  endtask

  task automatic set_w(input bit m, input bit v, input logic [7:0] d);
    if (m) begin m1_wvalid = v; m1_wdata = d; end
    else begin m0_wvalid = v; m0_wdata = d; end
  endtask

  task automatic set_rr(input bit m, input bit r);
    if (m) m1_rready = r; else m0_rready = r;
  endtask

  // Write burst; stall_beat >= 0 holds wvalid low for 3 cycles before that beat.
  task automatic do_write(input bit m, input int unsigned a, input int unsigned len,
                          input logic [7:0] d0, input int stall_beat);
    int unsigned wa;
    set_cmd(m, 1, 1, a, len);
    #1 chk("wr_cmd_ready", rdy(m), 1);
    chk("wr_other_ready", rdy(!m), 0);
    @(negedge clk);
    set_cmd(m, 0, 0, 0, 0);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_beat) begin
        for (int s = 0; s < 3; s++) begin
          set_w(m, 0, 8'h00);
          #1 chk("stall_we", ram_we, 0);
          chk("stall_busy", busy, 1);
          @(negedge clk);
        end
      end
      wa = (a + i) & 9'h1FF;
      set_w(m, 1, d0 + 8'(i));
      #1 chk("wr_we", ram_we, 1);
      chk("wr_waddr", ram_waddr, wa);
      chk("wr_wdata", ram_wdata, d0 + 8'(i));
      chk("wr_other_wready", m ? m0_wready : m1_wready, 0);
      exp_mem[wa] = d0 + 8'(i);
      @(negedge clk);
    end
    set_w(m, 0, 8'h00);
    #1 chk("wr_idle", busy, 0);
    chk("wr_no_we", ram_we, 0);
  endtask

  // Read burst; bp selects rready pattern 1,0,0,1 instead of constant 1.
  task automatic do_read(input bit m, input int unsigned a, input int unsigned len, input bit bp);
    int cyc, idx, first, res, pops, ahead_max;
    bit rv, rr, rl;
    logic [7:0] rd;
    logic [3:0] pat;
    pat = 4'b1001;
    set_cmd(m, 1, 0, a, len);
    #1 chk("rd_cmd_ready", rdy(m), 1);
    chk("rd_other_ready", rdy(!m), 0);
    @(negedge clk);
    set_cmd(m, 0, 0, 0, 0);
    cyc = 1; idx = 0; first = 0; res = 0; pops = 0; ahead_max = 0;
    while (idx <= int'(len) && cyc < 200) begin
      rr = bp ? pat[cyc % 4] : 1'b1;
      set_rr(m, rr);
      #1;
      rv = m ? m1_rvalid : m0_rvalid;
      rd = m ? m1_rdata : m0_rdata;
      rl = m ? m1_rlast : m0_rlast;
      if (ram_re) begin
        chk("rd_raddr", ram_raddr, (a + res) & 9'h1FF);
        res++;
      end
      chk("rd_other_rvalid", m ? m0_rvalid : m1_rvalid, 0);
      if (rv) begin
        if (first == 0) first = cyc;
        chk("rd_data", rd, exp_mem[(a + idx) & 9'h1FF]);
        chk("rd_last", rl, idx == int'(len));
        if (rr) begin pops++; idx++; end
      end
      if (res - pops > ahead_max) ahead_max = res - pops;
      if (idx <= int'(len)) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("rd_beats", idx, len + 1);
    chk("rd_re_count", res, len + 1);
    chk("rd_ahead_le2", ahead_max <= 2, 1);
    if (!bp) begin
      chk("rd_first_rvalid", first, 3);
      chk("rd_last_pop_cycle", cyc, 3 + len);
    end
    @(negedge clk);
    set_rr(m, 0);
    #1 chk("rd_idle", busy, 0);
  endtask

  // Both masters request a len=0 write; exp_w is the expected winner.
  task automatic contend(input bit exp_w, input int unsigned a, input logic [7:0] d);
    set_cmd(0, 1, 1, a, 0);
    set_cmd(1, 1, 1, a, 0);
    #1 chk("arb_m0_ready", m0_cmd_ready, !exp_w);
    chk("arb_m1_ready", m1_cmd_ready, exp_w);
    @(negedge clk);
    set_cmd(0, 0, 0, 0, 0);
    set_cmd(1, 0, 0, 0, 0);
    set_w(exp_w, 1, d);
    #1 chk("arb_wready", exp_w ? m1_wready : m0_wready, 1);
    chk("arb_we", ram_we, 1);
    chk("arb_wdata", ram_wdata, d);
    exp_mem[a] = d;
    @(negedge clk);
    set_w(exp_w, 0, 8'h00);
    #1 chk("arb_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops, cyc;
    for (int i = 0; i < 512; i++) begin
      mem[i]     = 8'(i) ^ 8'h5A;
      exp_mem[i] = 8'(i) ^ 8'h5A;
    end
    rst_n = 1'b0;
    set_cmd(0, 0, 0, 0, 0); set_cmd(1, 0, 0, 0, 0);
    set_w(0, 0, 0); set_w(1, 0, 0); set_rr(0, 0); set_rr(1, 0);

    // Reset state, with a request present that must not be acknowledged.
    @(negedge clk); @(negedge clk);
    m0_cmd_valid = 1'b1;
    #1 chk("rst_cmd_ready", m0_cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_re", ram_re, 0);
    chk("rst_rvalid", m0_rvalid, 0);
    m0_cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Strict alternation under contention, M0 first after reset.
    for (int k = 0; k < 8; k++) contend(k[0], 'h100 + k, 8'hC0 + 8'(k));

    // Single write then read back with rready held high.
    do_write(0, 'h010, 3, 8'hA0, -1);
    do_read(0, 'h010, 3, 0);

    // Address wrap at the top of the RAM.
    do_write(1, 'h1FE, 3, 8'hB0, -1);
    do_read(1, 'h1FE, 3, 0);

    // Write stall mid-burst.
    do_write(0, 'h040, 5, 8'hD0, 2);

    // Read with rready backpressure.
    do_read(1, 'h040, 7, 1);

    // Reset during beat 2 of a len=7 read.
    set_cmd(0, 1, 0, 'h010, 7);
    #1 chk("rr_cmd_ready", m0_cmd_ready, 1);
    @(negedge clk);
    set_cmd(0, 0, 0, 0, 0);
    set_rr(0, 1);
    pops = 0; cyc = 0;
    while (pops < 2 && cyc < 50) begin
      #1 if (m0_rvalid) pops++;
      @(negedge clk);
      cyc++;
    end
    set_rr(0, 0);
    #1 chk("rr_beat2_valid", m0_rvalid, 1);
    chk("rr_beat2_data", m0_rdata, exp_mem['h012]);
    rst_n = 1'b0;
    m1_cmd_valid = 1'b1;
    #1 chk("rr_busy", busy, 0);
    chk("rr_rvalid", m0_rvalid, 0);
    chk("rr_rdata", m0_rdata, 0);
    chk("rr_rlast", m0_rlast, 0);
    chk("rr_ram_re", ram_re, 0);
    chk("rr_ram_raddr", ram_raddr, 0);
    chk("rr_ram_we", ram_we, 0);
    chk("rr_m1_cmd_ready", m1_cmd_ready, 0);
    @(negedge clk);
    #1 chk("rr_hold_re", ram_re, 0);
    @(negedge clk);
    rst_n = 1'b1;
    contend(0, 'h080, 8'hE5);
    do_write(1, 'h081, 0, 8'hE6, -1);
    do_read(0, 'h080, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr_ram_burst_arbiter.md
# ddr_ram_burst_arbiter

Two-master burst arbiter and sequencer for the simple dual-port DDR memory model in the dma_s2mm testbench. Each master issues write or read burst commands. The block grants one burst at a time using round-robin arbitration. It then drives the RAM write port (we/waddr/wdata) or read port (re/raddr/rdata) beat by beat. Read data returns through a 2-entry output buffer with valid/ready backpressure, absorbing the RAM read latency.

## Interface
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 9, RAM address width; depth 2**ADDR_WIDTH.
- LEN_WIDTH, 8, burst length field width; beats = len+1.
- OUTPUT_REG, "TRUE", must match the RAM setting; "TRUE" = 1-cycle read latency, "FALSE" = 0-cycle.

- clk  in  1  single clock for the block and both RAM ports (wclk = rclk = clk).
- rst_n  in  1  asynchronous, active-low reset.
- mN_cmd_valid / mN_cmd_ready  in/out  1  command handshake, N = 0,1.
- mN_cmd_write  in  1  1 = write burst, 0 = read burst.
- mN_cmd_addr  in  ADDR_WIDTH  start word address.
- mN_cmd_len  in  LEN_WIDTH  beats minus one.
- mN_wdata  in  DATA_WIDTH  write beat data.
- mN_wvalid / mN_wready  in/out  1  write beat handshake.
- mN_rdata  out  DATA_WIDTH  read beat data.
- mN_rvalid / mN_rready  out/in  1  read beat handshake.
- mN_rlast  out  1  final beat of the read burst.
- ram_we  out  1; ram_waddr  out  ADDR_WIDTH; ram_wdata  out  DATA_WIDTH.
- ram_re  out  1; ram_raddr  out  ADDR_WIDTH; ram_rdata  in  DATA_WIDTH.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- **IDLE arbitration:**
  - Winner = the requesting master, if only one requests.
  - If both request, winner = the master not granted last.
  - After reset, M0 has priority.
  - Winner's cmd_ready is asserted combinationally in the same cycle. Addr/len/write are latched and the grant owner is recorded.
  - Next state is WRITE or READ. The loser's cmd_ready stays 0.
- **WRITE:**
  - Owner's wready = 1. The other master's wready = 0.
  - Each wvalid&&wready beat drives ram_we = 1, ram_waddr = cur_addr, ram_wdata = wdata in the same cycle.
  - cur_addr increments modulo 2**ADDR_WIDTH; wrap from max to 0 is silent.
  - Beat counter counts 0..len. After the beat with count == len, the state returns to IDLE.
  - wvalid low stalls with no RAM write.
- **READ:**
  - Issue ram_re = 1 with ram_raddr = cur_addr when occupancy + inflight − pop < 2. Here pop = rvalid&&rready this cycle and inflight = 1 if re was issued last cycle (OUTPUT_REG "TRUE" only).
  - ram_rdata is pushed to the buffer one cycle after re (OUTPUT_REG "TRUE") or in the same cycle as re ("FALSE").
  - ram_re is held low otherwise. The RAM output register only updates while re is high, so no extra re is ever issued.
  - After the len+1-th re, the state moves to DRAIN.
- **DRAIN:**
  - No re is issued. When the buffer is empty and nothing is in flight, the state returns to IDLE.
- **Output buffer:**
  - 2-entry FIFO. Head drives the owner's rdata/rvalid; the other master's rvalid = 0.
  - Each entry carries a last flag, set on the beat with index len.
  - Simultaneous push and pop keeps the occupancy unchanged.
- Only one burst is outstanding at a time, so there is no read/write address hazard.
- **Reset (asynchronous, any state, including mid-burst):**
  - State goes to IDLE and the buffer is emptied.
  - Last-grant is set so M0 wins next.
  - All outputs go to 0: cmd_ready, wready, rvalid, rlast, rdata, ram_we, ram_re, ram_waddr, ram_raddr, ram_wdata, busy.
  - An aborted burst issues no further RAM writes.

## Timing
- Command accept cycle C: cmd_ready = 1.
- Write: the first beat is accepted at C+1 at the earliest. A len = L burst with wvalid held high completes at C+1+L. IDLE at C+2+L, next command acceptable at C+2+L.
- Read, OUTPUT_REG "TRUE": first re at C+1, data in buffer at C+2, first rvalid at C+3.
- Read, OUTPUT_REG "FALSE": first rvalid at C+2.
- With rready held high, reads sustain 1 beat per cycle.
- rlast is asserted together with the final rvalid. IDLE follows the cycle after the final pop.
- ram_we and ram_re are single-cycle per beat and never asserted outside WRITE/READ.

## Test plan
- **Single write then read:** M0 writes len=3 at addr 0x010 with data 0xA0..0xA3 -> ram_we pulses at 0x010..0x013. Then M0 reads len=3 at 0x010 -> rdata 0xA0..0xA3, rlast on 0xA3, first rvalid 3 cycles after cmd accept (OUTPUT_REG "TRUE").
- **Contention:** M0 and M1 both assert cmd_valid in the same IDLE cycle after reset -> M0 granted. Next simultaneous request -> M1 granted. Strict alternation over 8 bursts.
- **Wrap-around:** write len=3 at 0x1FE (ADDR_WIDTH=9) -> ram_waddr sequence 0x1FE, 0x1FF, 0x000, 0x001. Read-back of the same range matches.
- **Backpressure:** read len=7 with rready toggling 1,0,0,1 -> no more than 2 beats buffered, at most 2 re ahead of pops, no data lost or duplicated, rdata order preserved.
- **Write stall:** wvalid deasserted for 3 cycles mid-burst -> ram_we stays 0 during the gap and the address does not advance.
- **Reset mid-read:** assert rst_n = 0 during beat 2 of a len=7 read -> all outputs 0 immediately, busy = 0. After release, an M1 request waits while M0 wins a simultaneous request.
